ps2_cmd_sequencer: RTL

Sequences all command traffic into the PS/2 transceiver (command/ack/receive interface of PS2_Controller, instantiated with INITIALIZE_MOUSE=0).
- After reset, runs a fixed mouse init script: reset, BAT wait, sample rate 200, enable streaming.
- Afterwards, arbitrates single host (CPU/register) commands onto the transceiver.
- Consumes ACK/RESEND/ERROR responses, retries on resend, times out.
- Forwards all other received bytes as a data stream to the packet decoder.

---
 rtl/ps2_cmd_sequencer_if.sv | 43 ++++
 rtl/ps2_cmd_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_cmd_sequencer_if.sv
// ============================================================================
// Module  : ps2_cmd_sequencer_if
// Purpose : host command, PS/2 transceiver and stream bundle for the sequencer
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface ps2_cmd_sequencer_if;
  logic [7:0] host_cmd;
  logic       host_cmd_valid;
  logic       host_cmd_ready;
  logic [7:0] host_rsp;
  logic       host_rsp_valid;
  logic       host_rsp_err;
  logic [7:0] ps2_cmd;
  logic       ps2_send;
  logic       ps2_sent;
  logic       ps2_tx_err;
  logic [7:0] ps2_rx_data;
  logic       ps2_rx_en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       init_done;
  logic       init_err;
  logic       busy;

  // Environment side: host plus transceiver
  modport master (
    output host_cmd, host_cmd_valid, ps2_sent, ps2_tx_err, ps2_rx_data, ps2_rx_en,
    input  host_cmd_ready, host_rsp, host_rsp_valid, host_rsp_err, ps2_cmd, ps2_send,
           rx_data, rx_valid, init_done, init_err, busy
  );

  // Sequencer side
  modport slave (
    input  host_cmd, host_cmd_valid, ps2_sent, ps2_tx_err, ps2_rx_data, ps2_rx_en,
    output host_cmd_ready, host_rsp, host_rsp_valid, host_rsp_err, ps2_cmd, ps2_send,
           rx_data, rx_valid, init_done, init_err, busy
  );
endinterface

`default_nettype wire

// File: rtl/ps2_cmd_sequencer.sv
// ============================================================================
// Module  : ps2_cmd_sequencer
// Purpose : mouse init script, host command arbitration, ACK/retry handling
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ps2_cmd_sequencer #(
  parameter int ACK_TIMEOUT_CYC = 1250000,
  parameter int BAT_TIMEOUT_CYC = 50000000,
  parameter int MAX_RETRY       = 3,
  parameter bit INIT_ENABLE     = 1'b1
) (
  input logic                CLOCK_50,
  input logic                reset_n,
  ps2_cmd_sequencer_if.slave bus
);

  localparam int c_tmr_max = (ACK_TIMEOUT_CYC > BAT_TIMEOUT_CYC) ? ACK_TIMEOUT_CYC : BAT_TIMEOUT_CYC;
  localparam int c_tmr_w   = $clog2(c_tmr_max + 1);
  localparam int c_rty_w   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [c_tmr_w-1:0] c_ack_load = c_tmr_w'(ACK_TIMEOUT_CYC - 1);
  localparam logic [c_tmr_w-1:0] c_bat_load = c_tmr_w'(BAT_TIMEOUT_CYC - 1);
  localparam logic [c_rty_w-1:0] c_max_rty  = c_rty_w'(MAX_RETRY);

  localparam logic [2:0] c_st_init_load = 3'd0;
  localparam logic [2:0] c_st_send      = 3'd1;
  localparam logic [2:0] c_st_wait_ack  = 3'd2;
  localparam logic [2:0] c_st_wait_bat  = 3'd3;
  localparam logic [2:0] c_st_wait_id   = 3'd4;
  localparam logic [2:0] c_st_next      = 3'd5;
  localparam logic [2:0] c_st_fail      = 3'd6;
  localparam logic [2:0] c_st_idle      = 3'd7;
  localparam logic [2:0] c_st_reset     = INIT_ENABLE ? c_st_init_load : c_st_idle;

  logic [1:0]         r_rst_sync;
  logic               w_rst_n;
  logic [2:0]         r_state;
  logic [2:0]         w_next;
  logic               w_consume;
  logic [7:0]         w_fail_code;
  logic [7:0]         w_rom;
  logic [7:0]         r_cmd;
  logic [1:0]         r_ptr;
  logic [c_rty_w-1:0] r_retry;
  logic [c_tmr_w-1:0] r_timer;
  logic               r_init_mode;
  logic [7:0]         r_fail_code;
  logic               r_init_done;
  logic               r_init_err;
  logic               r_busy;
  logic               r_ready;
  logic [7:0]         r_rx_data;
  logic               r_rx_valid;
  logic               w_tmr_zero;
  logic               w_rsp_valid;
  logic               w_rsp_err;
  logic [7:0]         w_rsp;

  // Asynchronous assertion, synchronous release
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  always_comb begin
    case (r_ptr)
      2'd0:    w_rom = 8'hFF;
      2'd1:    w_rom = 8'hF3;
      2'd2:    w_rom = 8'hC8;
      default: w_rom = 8'hF4;
    endcase
  end

  assign w_tmr_zero = (r_timer == '0);

  always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= c_st_reset;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_consume   = 1'b0;
    w_fail_code = 8'h00;
    case (r_state)
      c_st_init_load: w_next = c_st_send;
      c_st_send: begin
        if (bus.ps2_sent)        w_next = c_st_wait_ack;
        else if (bus.ps2_tx_err) w_next = c_st_fail;
      end
      c_st_wait_ack: begin
        if (bus.ps2_rx_en) begin
          case (bus.ps2_rx_data)
            8'hFA: begin
              w_consume = 1'b1;
              w_next    = (r_init_mode && r_cmd == 8'hFF) ? c_st_wait_bat : c_st_next;
            end
            8'hFE: begin
              w_consume = 1'b1;
              w_next    = (r_retry < c_max_rty) ? c_st_send : c_st_fail;
            end
            8'hFC: begin
              w_consume   = 1'b1;
              w_fail_code = 8'hFC;
              w_next      = c_st_fail;
            end
            default: w_next = c_st_wait_ack;
          endcase
        end else if (w_tmr_zero) begin
          w_next = c_st_fail;
        end
      end
      c_st_wait_bat: begin
        if (bus.ps2_rx_en && bus.ps2_rx_data == 8'hAA) begin
          w_consume = 1'b1;
          w_next    = c_st_wait_id;
        end else if (bus.ps2_rx_en && bus.ps2_rx_data == 8'hFC) begin
          w_consume   = 1'b1;
          w_fail_code = 8'hFC;
          w_next      = c_st_fail;
        end else if (w_tmr_zero && !bus.ps2_rx_en) begin
          w_next = c_st_fail;
        end
      end
      c_st_wait_id: begin
        // Keyboards send no ID byte, so silence here is not an error
        if (bus.ps2_rx_en) begin
          w_consume = 1'b1;
          w_next    = c_st_next;
        end else if (w_tmr_zero) begin
          w_next = c_st_next;
        end
      end
      c_st_next: begin
        if (r_init_mode && r_ptr != 2'd3) w_next = c_st_init_load;
        else                              w_next = c_st_idle;
      end
      c_st_fail: w_next = c_st_idle;
      default: begin
        if (bus.host_cmd_valid && r_ready) w_next = c_st_send;
      end
    endcase
  end

  always_comb begin
    w_rsp_valid = !r_init_mode && (r_state == c_st_next || r_state == c_st_fail);
    w_rsp_err   = !r_init_mode && (r_state == c_st_fail);
    w_rsp       = 8'h00;
    if (w_rsp_valid) w_rsp = w_rsp_err ? r_fail_code : 8'hFA;
  end

  always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cmd       <= 8'h00;
      r_ptr       <= 2'd0;
      r_retry     <= '0;
      r_timer     <= '0;
      r_init_mode <= INIT_ENABLE;
      r_fail_code <= 8'h00;
      r_init_done <= !INIT_ENABLE;
      r_init_err  <= 1'b0;
      r_busy      <= 1'b0;
      r_ready     <= 1'b0;
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
    end else begin
      r_busy  <= (w_next != c_st_idle);
      r_ready <= (w_next == c_st_idle);

      if (r_state == c_st_init_load) begin
        r_cmd   <= w_rom;
        r_retry <= '0;
      end else if (r_state == c_st_idle && w_next == c_st_send) begin
        r_cmd   <= bus.host_cmd;
        r_retry <= '0;
      end else if (r_state == c_st_wait_ack && w_next == c_st_send) begin
        r_retry <= r_retry + 1'b1;
      end

      if (w_next != r_state) begin
        case (w_next)
          c_st_wait_ack: r_timer <= c_ack_load;
          c_st_wait_bat: r_timer <= c_bat_load;
          c_st_wait_id:  r_timer <= c_ack_load;
          default:       r_timer <= r_timer;
        endcase
      end else if (!w_tmr_zero) begin
        r_timer <= r_timer - 1'b1;
      end

      if (w_next == c_st_fail && r_state != c_st_fail) r_fail_code <= w_fail_code;

      if (r_init_mode && r_state == c_st_next) begin
        r_ptr <= r_ptr + 1'b1;
        if (r_ptr == 2'd3) r_init_done <= 1'b1;
      end
      if (r_init_mode && r_state == c_st_fail) begin
        r_init_done <= 1'b1;
        r_init_err  <= 1'b1;
      end
      if ((r_state == c_st_next || r_state == c_st_fail) && w_next == c_st_idle)
        r_init_mode <= 1'b0;

      r_rx_valid <= bus.ps2_rx_en && !w_consume;
      if (bus.ps2_rx_en && !w_consume) r_rx_data <= bus.ps2_rx_data;
    end
  end

  assign bus.ps2_cmd        = r_cmd;
  assign bus.ps2_send       = (r_state == c_st_send);
  assign bus.host_cmd_ready = r_ready;
  assign bus.busy           = r_busy;
  assign bus.host_rsp       = w_rsp;
  assign bus.host_rsp_valid = w_rsp_valid;
  assign bus.host_rsp_err   = w_rsp_err;
  assign bus.rx_data        = r_rx_data;
  assign bus.rx_valid       = r_rx_valid;
  assign bus.init_done      = r_init_done;
  assign bus.init_err       = r_init_err;

endmodule

`default_nettype wire
